// File: rtl/funrv32_pkg.sv
// funRV32 shared definitions.
// Register-file widths, register indices and FSM states.
package funrv32_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREG  = 32;
  localparam int RF_AW    = 5;
  localparam int REG_ZERO = 0;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_t;

endpackage

// File: rtl/funrv32_regfile_rdport.sv
// funRV32 register file read lane.
// Selects zero / out-of-range / forward / array, then registers with hold.
module funrv32_regfile_rdport
  import funrv32_pkg::*;
#(
  parameter int XLEN    = RF_XLEN,
  parameter int NREG    = RF_NREG,
  parameter int AW      = RF_AW,
  parameter int FORWARD = 1,
  parameter int ZERO_X0 = 1
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            en,
  input  logic [AW-1:0]   ra,
  input  logic            wr,
  input  logic [AW-1:0]   ad,
  input  logic [XLEN-1:0] rd,
  input  logic [XLEN-1:0] arr,
  output logic [XLEN-1:0] r
);

  localparam logic [AW:0] NREG_W = NREG[AW:0];

  logic            is_zero;
  logic            is_oor;
  logic            is_fwd;
  logic [XLEN-1:0] nxt;

  assign is_zero = (ZERO_X0 != 0) && (ra == REG_ZERO[AW-1:0]);
  assign is_oor  = {1'b0, ra} >= NREG_W;
  // wr is only high for writable addresses, so the cases are exclusive
  assign is_fwd  = (FORWARD != 0) && wr && (ad == ra);

  always_comb begin
    nxt = arr;
    unique case (1'b1)
      is_zero: nxt = '0;
      is_oor:  nxt = '0;
      is_fwd:  nxt = rd;
      default: nxt = arr;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r <= '0;
    end else if (en) begin
      r <= nxt;
    end
  end

endmodule

// File: rtl/funrv32_regfile.sv
// funRV32 integer register file.
// N read lanes, optional forwarding, hardwired x0, post-reset clear.
module funrv32_regfile
  import funrv32_pkg::*;
#(
  parameter int XLEN    = RF_XLEN,
  parameter int NREG    = RF_NREG,
  parameter int AW      = RF_AW,
  parameter int NRP     = 2,
  parameter int FORWARD = 1,
  parameter int ZERO_X0 = 1
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                we,
  input  logic [AW-1:0]       ad,
  input  logic [XLEN-1:0]     rd,
  input  logic [NRP-1:0]      re,
  input  logic [NRP*AW-1:0]   ra,
  output logic [NRP*XLEN-1:0] r,
  output logic                ready
);

  localparam int          IW     = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int          LASTI  = NREG - 1;
  localparam logic [AW:0] LAST   = LASTI[AW:0];
  localparam logic [AW:0] NREG_W = NREG[AW:0];

  rf_state_t       state;
  logic [AW:0]     cnt;
  logic [XLEN-1:0] mem [NREG];
  logic            clr_we;
  logic            wr_ok;

  // no clear writes while reset is held, so the array stays untouched
  assign clr_we = (state == RF_CLEAR) && resetb;
  assign wr_ok  = (state == RF_READY) && we
               && ({1'b0, ad} < NREG_W)
               && !((ZERO_X0 != 0) && (ad == REG_ZERO[AW-1:0]));

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= RF_CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      unique case (state)
        RF_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= RF_READY;
            ready <= 1'b1;
          end
        end
        RF_READY: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt[IW-1:0]] <= '0;
    end else if (wr_ok) begin
      mem[ad[IW-1:0]] <= rd;
    end
  end

  for (genvar g = 0; g < NRP; g++) begin : g_rd
    funrv32_regfile_rdport #(
      .XLEN    (XLEN),
      .NREG    (NREG),
      .AW      (AW),
      .FORWARD (FORWARD),
      .ZERO_X0 (ZERO_X0)
    ) u_rd (
      .clk    (clk),
      .resetb (resetb),
      .en     (re[g] && ready),
      .ra     (ra[g*AW +: AW]),
      .wr     (wr_ok),
      .ad     (ad),
      .rd     (rd),
      .arr    (mem[ra[g*AW +: IW]]),
      .r      (r[g*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_funrv32_regfile.sv
// Bench for funrv32_regfile: default config plus an alternate
// (NREG=24, no forwarding, ordinary x0) driven by the same stimulus.
module tb_funrv32_regfile;

  logic        clk = 1'b0;
  logic        resetb;
  logic        we;
  logic [4:0]  ad;
  logic [31:0] rd;
  logic [1:0]  re;
  logic [9:0]  ra;
  logic [63:0] r0, r1;
  logic        rdy0, rdy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  funrv32_regfile #(
    .XLEN(32), .NREG(32), .AW(5), .NRP(2), .FORWARD(1), .ZERO_X0(1)
  ) dut (
    .clk(clk), .resetb(resetb), .we(we), .ad(ad), .rd(rd),
    .re(re), .ra(ra), .r(r0), .ready(rdy0)
  );

  funrv32_regfile #(
    .XLEN(32), .NREG(24), .AW(5), .NRP(2), .FORWARD(0), .ZERO_X0(0)
  ) alt (
    .clk(clk), .resetb(resetb), .we(we), .ad(ad), .rd(rd),
    .re(re), .ra(ra), .r(r1), .ready(rdy1)
  );

  // reference model: c=0 default instance, c=1 alternate
  logic [31:0] mm [2][32];
  logic [31:0] er [2][2];
  int          mcyc [2];

  function automatic int nreg(int c);
    return (c == 0) ? 32 : 24;
  endfunction

  function automatic bit wable(int c, int a);
    return (a < nreg(c)) && !((c == 0) && (a == 0));
  endfunction

  function automatic logic [31:0] mread(int c, int a);
    if ((c == 0) && (a == 0)) return 32'h0;
    if (a >= nreg(c)) return 32'h0;
    if ((c == 0) && we && (int'(ad) == a) && wable(c, a)) return rd;
    return mm[c][a];
  endfunction

  task automatic model_edge();
    if (!resetb) return;
    for (int c = 0; c < 2; c++) begin
      if (mcyc[c] < nreg(c)) begin
        mcyc[c]++;
        if (mcyc[c] == nreg(c))
          for (int a = 0; a < 32; a++) mm[c][a] = 32'h0;
      end else begin
        for (int i = 0; i < 2; i++)
          if (re[i]) er[c][i] = mread(c, int'(ra[i*5 +: 5]));
        if (we && wable(c, int'(ad))) mm[c][ad] = rd;
      end
    end
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk($sformatf("%s dut.ready", tag), 64'(rdy0), 64'(mcyc[0] >= nreg(0)));
    chk($sformatf("%s alt.ready", tag), 64'(rdy1), 64'(mcyc[1] >= nreg(1)));
    chk($sformatf("%s dut.r0", tag), 64'(r0[31:0]),  64'(er[0][0]));
    chk($sformatf("%s dut.r1", tag), 64'(r0[63:32]), 64'(er[0][1]));
    chk($sformatf("%s alt.r0", tag), 64'(r1[31:0]),  64'(er[1][0]));
    chk($sformatf("%s alt.r1", tag), 64'(r1[63:32]), 64'(er[1][1]));
  endtask

  task automatic tick(string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic hit_reset(string tag);
    resetb = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      mcyc[c] = 0;
      er[c][0] = 32'h0;
      er[c][1] = 32'h0;
    end
    check_all(tag);
  endtask

  task automatic wait_ready(string tag);
    int n;
    int n1;
    n  = 0;
    n1 = -1;
    while (!rdy0 && n < 100) begin
      tick(tag);
      n++;
      if (rdy1 && n1 < 0) n1 = n;
    end
    chk($sformatf("%s dut cycles to ready", tag), 64'(n), 64'(32));
    chk($sformatf("%s alt cycles to ready", tag), 64'(n1), 64'(24));
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  ad;
    logic [31:0] rd;
    logic [1:0]  re;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] f0;
  } vec_t;

  vec_t tv [12];

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 2'b00, 5'd0,  5'd0,
               32'h0,        32'h0,        32'h0};
    tv[1]  = '{1'b1, 5'd31, 32'h12345678, 2'b00, 5'd0,  5'd0,
               32'h0,        32'h0,        32'h0};
    tv[2]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd5,  5'd31,
               32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
    tv[3]  = '{1'b1, 5'd7,  32'h00000001, 2'b00, 5'd5,  5'd31,
               32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
    tv[4]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 2'b01, 5'd7,  5'd0,
               32'hA5A5A5A5, 32'h12345678, 32'h00000001};
    tv[5]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 2'b00, 5'd7,  5'd0,
               32'hA5A5A5A5, 32'h12345678, 32'h00000001};
    tv[6]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd0,  5'd7,
               32'h0,        32'hA5A5A5A5, 32'hFFFFFFFF};
    tv[7]  = '{1'b0, 5'd0,  32'h0,        2'b01, 5'd5,  5'd5,
               32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF};
    tv[8]  = '{1'b0, 5'd0,  32'h0,        2'b10, 5'd5,  5'd5,
               32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    tv[9]  = '{1'b0, 5'd0,  32'h0,        2'b00, 5'd5,  5'd31,
               32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    tv[10] = '{1'b0, 5'd0,  32'h0,        2'b10, 5'd5,  5'd31,
               32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
    tv[11] = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd31, 5'd31,
               32'h12345678, 32'h12345678, 32'h0};

    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 32; a++) mm[c][a] = 32'h0;
    we = 1'b0; ad = '0; rd = '0; re = '0; ra = '0;

    // power-on reset, then a write attempt and reset during clear
    hit_reset("por");
    tick("por hold");
    tick("por hold");
    resetb = 1'b1;
    we = 1'b1; ad = 5'd3; rd = 32'hCAFEF00D;
    re = 2'b11; ra = {5'd31, 5'd3};
    repeat (10) tick("clear");
    hit_reset("rst in clear");
    tick("clear hold");
    tick("clear hold");
    resetb = 1'b1;
    wait_ready("rel");
    we = 1'b0;

    for (int a = 0; a < 32; a++) begin
      re = 2'b11;
      ra = {5'(31 - a), 5'(a)};
      tick("sweep");
      chk($sformatf("sweep x%0d lane0", a), 64'(r0[31:0]), 64'h0);
      chk($sformatf("sweep x%0d lane1", 31 - a), 64'(r0[63:32]), 64'h0);
    end

    foreach (tv[k]) begin
      we = tv[k].we; ad = tv[k].ad; rd = tv[k].rd;
      re = tv[k].re; ra = {tv[k].a1, tv[k].a0};
      tick($sformatf("vec%0d", k));
      chk($sformatf("vec%0d dut lane0", k), 64'(r0[31:0]),  64'(tv[k].e0));
      chk($sformatf("vec%0d dut lane1", k), 64'(r0[63:32]), 64'(tv[k].e1));
      chk($sformatf("vec%0d alt lane0", k), 64'(r1[31:0]),  64'(tv[k].f0));
    end

    for (int k = 0; k < 2000; k++) begin
      we = 1'($urandom);
      rd = $urandom;
      re = 2'($urandom);
      ra = 10'($urandom);
      ad = ($urandom_range(0, 3) == 0) ? ra[4:0] : 5'($urandom_range(0, 31));
      tick("rand");
    end

    // reset asserted mid-cycle during READY traffic
    we = 1'b1; ad = 5'd5; rd = 32'h13579BDF; re = 2'b11; ra = {5'd5, 5'd31};
    tick("pre rst");
    #3;
    hit_reset("rst in ready");
    tick("ready hold");
    resetb = 1'b1;
    we = 1'b1; ad = 5'd3; rd = 32'h0BADF00D;
    wait_ready("rel2");
    we = 1'b0; re = 2'b11; ra = {5'd5, 5'd3};
    tick("post");
    chk("post x3 lane0", 64'(r0[31:0]),  64'h0);
    chk("post x5 lane1", 64'(r0[63:32]), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
